poa_slot_scheduler: RTL
=======================

POA_SLOT_SCHEDULER -- requirements
Module: poa_slot_scheduler

Interface
REQ-001 The block SHALL have the following parameter: NUM_VALIDATORS, 4, number of requesting validators (2..16).
REQ-002 The block SHALL have the following parameter: SLOT_CYCLES, 8, idle cycles before leadership rotates (≥2).
REQ-003 The block SHALL have the following parameter: RESULT_LAT, 2, wait cycles from validate_block to block_valid sample (≥1).
REQ-004 The block SHALL have the following port: clk  in  1  single clock; all state on rising edge.
REQ-005 The block SHALL have the following port: reset  in  1  asynchronous, active-low reset.
REQ-006 The block SHALL have the following port: req  in  NUM_VALIDATORS  per-validator block-submission request (level).
REQ-007 The block SHALL have the following port: block_id_in  in  32*NUM_VALIDATORS  packed block ids; validator i at [32i+31:32i].
REQ-008 The block SHALL have the following port: validate_block  out  1  one-cycle strobe to the PoA validator datapath.
REQ-009 The block SHALL have the following port: block_id  out  32  block id presented to the datapath.
REQ-010 The block SHALL have the following port: validator_id  out  32  validator id presented to the datapath (index+1).
REQ-011 The block SHALL have the following port: block_valid  in  1  datapath verdict.
REQ-012 The block SHALL have the following port: leader  out  $clog2(NUM_VALIDATORS)  current slot leader index.
REQ-013 The block SHALL have the following port: grant  out  NUM_VALIDATORS  one-hot completion to the served validator, high only with done.
REQ-014 The block SHALL have the following port: done  out  1  one-cycle completion pulse.
REQ-015 The block SHALL have the following port: accepted  out  1  verdict of the last transaction; held until the next REPORT.

Function
REQ-016 The FSM SHALL have the states IDLE, ISSUE, WAIT and REPORT.
REQ-017 In IDLE, when req[leader]=1, the block SHALL latch block_id_in slice[leader] into block_id and set validator_id=leader+1, then enter ISSUE.
REQ-018 In ISSUE, validate_block SHALL be 1 for exactly one cycle; the next state is WAIT.
REQ-019 WAIT SHALL last exactly RESULT_LAT cycles; on its last cycle block_valid SHALL be sampled into accepted, and the next state is REPORT.
REQ-020 In REPORT, done=1 and grant[leader]=1 for one cycle; the next state is IDLE, leader advances by one and the slot counter clears.
REQ-021 Latency SHALL be: req seen at edge k gives validate_block high in cycle k+1 and done in cycle k+2+RESULT_LAT.
REQ-022 The slot counter SHALL count only in IDLE; when it reaches SLOT_CYCLES-1 with req[leader]=0, leader SHALL advance and the counter SHALL clear.
REQ-023 A simultaneous slot expiry and req[leader]=1 SHALL dispatch the request; leader advances only after REPORT.
REQ-024 Leader SHALL wrap from NUM_VALIDATORS-1 to 0.
REQ-025 Requests from non-leaders SHALL be ignored and SHALL NOT be cleared; the block serves at most one block per slot.
REQ-026 req deassertion or a block_id_in change during ISSUE/WAIT SHALL NOT affect the in-flight transaction.
REQ-027 block_id and validator_id SHALL hold their last values between transactions.

Reset
REQ-028 Reset low SHALL force, asynchronously and at any state, the following: state=IDLE, leader=0, slot counter=0, validate_block=0, block_id=0, validator_id=0, grant=0, done=0, accepted=0.
REQ-029 An in-flight transaction SHALL be abandoned without a done pulse.
REQ-030 The first leader after reset release SHALL be 0.

Configuration
REQ-031 With POA_STATS_EN defined, the block SHALL add the outputs accept_cnt[15:0] and reject_cnt[15:0]. Each increments in REPORT per the verdict, saturates at 0xFFFF and resets to 0.
REQ-032 Without POA_STATS_EN, these ports and counters SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-033 The package poa_pkg SHALL hold the FSM state enum (poa_sched_state_t), the width constant POA_ID_W=32 and the stats width POA_STAT_W=16.
REQ-034 The slot/leader rotation counter SHALL be the sub-module poa_slot_timer (inputs: count-enable, advance; outputs: leader, expiry).

Verification
REQ-035 Bench scenario (N=4, SLOT=8, LAT=2): reset released, req=0001, slot0 id=101, block_valid=1 -> validate_block pulse with validator_id=1, block_id=101; done, grant=0001, accepted=1 four cycles later; leader=1.
REQ-036 Bench scenario: leader=1, req=0010, id=102, block_valid=0 -> validator_id=2; done with accepted=0; leader=2.
REQ-037 Bench scenario: leader=0, req=0100 only -> no validate_block for 16 cycles; leader 1 at cycle 8, leader 2 at cycle 16; then dispatch with validator_id=3.
REQ-038 Bench scenario: leader=3 completes a transaction -> leader wraps to 0.
REQ-039 Bench scenario: reset asserted during WAIT -> all outputs 0 immediately; no done; leader=0 after release.
REQ-040 Bench scenario (POA_STATS_EN): 3 accepted then 1 rejected -> accept_cnt=3, reject_cnt=1; counter forced to 0xFFFF stays 0xFFFF after a further accept.

Source files
------------

// File: rtl/poa_pkg.sv
// Shared types and widths for the PoA slot scheduler.
package poa_pkg;
    localparam int POA_ID_W   = 32;
    localparam int POA_STAT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        REPORT
    } poa_sched_state_t;
endpackage

// File: rtl/poa_slot_timer.sv
// Slot timer: counts idle cycles in the current slot and rotates the leader index.
module poa_slot_timer #(
    parameter int NUM_VALIDATORS = 4,
    parameter int SLOT_CYCLES    = 8,
    localparam int LW = $clog2(NUM_VALIDATORS),
    localparam int CW = $clog2(SLOT_CYCLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          count_en,
    input  logic          advance,
    output logic [LW-1:0] leader,
    output logic          expiry
);
    logic [CW-1:0] cnt;

    assign expiry = count_en && (cnt == CW'(SLOT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            leader <= '0;
        end else if (advance) begin
            cnt    <= '0;
            leader <= (leader == LW'(NUM_VALIDATORS - 1)) ? '0 : leader + 1'b1;
        end else if (count_en) begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/poa_slot_scheduler.sv
// Round-robin PoA slot scheduler: serves the slot leader's block through the validator datapath.
// Optional POA_STATS_EN adds saturating accept/reject counters.
module poa_slot_scheduler
    import poa_pkg::*;
#(
    parameter int NUM_VALIDATORS = 4,
    parameter int SLOT_CYCLES    = 8,
    parameter int RESULT_LAT     = 2,
    localparam int LW = $clog2(NUM_VALIDATORS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_VALIDATORS-1:0]    req,
    input  logic [32*NUM_VALIDATORS-1:0] block_id_in,
    output logic                         validate_block,
    output logic [POA_ID_W-1:0]          block_id,
    output logic [POA_ID_W-1:0]          validator_id,
    input  logic                         block_valid,
    output logic [LW-1:0]                leader,
    output logic [NUM_VALIDATORS-1:0]    grant,
    output logic                         done,
`ifdef POA_STATS_EN
    output logic [POA_STAT_W-1:0]        accept_cnt,
    output logic [POA_STAT_W-1:0]        reject_cnt,
`endif
    output logic                         accepted
);
    localparam int WW = $clog2(RESULT_LAT + 1);

    poa_sched_state_t state, state_nxt;
    logic [WW-1:0]    wcnt;
    logic             dispatch, last_wait, expiry, advance;

    assign dispatch  = (state == IDLE) && req[leader];
    assign last_wait = (state == WAIT) && (wcnt == WW'(RESULT_LAT - 1));
    // A pending leader request wins over slot expiry; the leader moves on after REPORT.
    assign advance   = (state == REPORT) || (expiry && !req[leader]);

    poa_slot_timer #(
        .NUM_VALIDATORS(NUM_VALIDATORS),
        .SLOT_CYCLES   (SLOT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .count_en(state == IDLE),
        .advance (advance),
        .leader  (leader),
        .expiry  (expiry)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        validate_block = 1'b0;
        done           = 1'b0;
        grant          = '0;
        case (state)
            IDLE:   if (dispatch) state_nxt = ISSUE;
            ISSUE: begin
                validate_block = 1'b1;
                state_nxt      = WAIT;
            end
            WAIT:   if (last_wait) state_nxt = REPORT;
            REPORT: begin
                done          = 1'b1;
                grant[leader] = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt         <= '0;
            block_id     <= '0;
            validator_id <= '0;
            accepted     <= 1'b0;
        end else begin
            wcnt <= (state == WAIT) ? wcnt + 1'b1 : '0;
            if (dispatch) begin
                block_id     <= block_id_in[32*leader +: 32];
                validator_id <= {{(POA_ID_W-LW){1'b0}}, leader} + 1'b1;
            end
            if (last_wait) accepted <= block_valid;
        end
    end

`ifdef POA_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accept_cnt <= '0;
            reject_cnt <= '0;
        end else if (state == REPORT) begin
            if (accepted && accept_cnt != '1)       accept_cnt <= accept_cnt + 1'b1;
            else if (!accepted && reject_cnt != '1) reject_cnt <= reject_cnt + 1'b1;
        end
    end
`endif
endmodule
